// File: rtl/mux_scan_controller_pkg.sv
// Shared constants for the 4:1 mux scan controller: state encoding, channel ids, defaults.
package mux_scan_controller_pkg;

    localparam int unsigned N_CH          = 4;
    localparam int unsigned CH_W          = 2;
    localparam int unsigned DEFAULT_DWELL = 2;
    localparam int unsigned DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [CH_W-1:0] CH0 = 2'd0;
    localparam logic [CH_W-1:0] CH1 = 2'd1;
    localparam logic [CH_W-1:0] CH2 = 2'd2;
    localparam logic [CH_W-1:0] CH3 = 2'd3;

endpackage

// File: rtl/mux_scan_controller_if.sv
// Handshake, mux select and result signals between the scan controller and its environment.
interface mux_scan_controller_if;
    import mux_scan_controller_pkg::*;

    logic            start;
    logic            continuous;
    logic            y_in;
    logic            s0;
    logic            s1;
    logic            busy;
    logic            done;
    logic [N_CH-1:0] sample;
    logic            sample_valid;

    // Environment side: requests scans and returns the mux output.
    modport master (
        output start, continuous, y_in,
        input  s0, s1, busy, done, sample, sample_valid
    );

    // Controller side.
    modport slave (
        input  start, continuous, y_in,
        output s0, s1, busy, done, sample, sample_valid
    );

endinterface

// File: rtl/mux_scan_controller_dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while enabled, wraps at terminal count, clear forces zero.
module mux_scan_controller_dwell_counter #(
    parameter int unsigned DWELL = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);

    logic [CNT_W-1:0] cnt_q;

    assign tc_c = (cnt_q == CNT_W'(DWELL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= tc_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux_scan_controller.sv
// Steps the mux select through channels 0..3, samples y per channel and publishes a 4-bit word.
module mux_scan_controller
    import mux_scan_controller_pkg::*;
#(
    parameter int unsigned DWELL = DEFAULT_DWELL,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_scan_controller_if.slave bus
);

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [N_CH-1:0]   shadow_q, shadow_d;
    logic [N_CH-1:0]   sample_q, sample_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic              tc_c;

    mux_scan_controller_dwell_counter #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q != ST_SCAN),
        .enable (state_q == ST_SCAN),
        .tc_c   (tc_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ch_q     <= CH0;
            shadow_q <= '0;
            sample_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            shadow_q <= shadow_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
        end
    end

    // The final capture publishes the whole word on entry to DONE so it lines up with the done pulse.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        shadow_d = shadow_q;
        sample_d = sample_q;
        valid_d  = valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SCAN;
                    ch_d    = CH0;
                end
            end
            ST_SCAN: begin
                if (tc_c) begin
                    shadow_d[ch_q] = bus.y_in;
                    if (ch_q == CH3) begin
                        state_d  = ST_DONE;
                        ch_d     = CH0;
                        sample_d = shadow_d;
                        valid_d  = 1'b1;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end
            end
            ST_DONE: begin
                ch_d    = CH0;
                state_d = bus.continuous ? ST_SCAN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ch_d    = CH0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Select lines come straight from the channel flops; channel is forced to 0 outside SCAN.
    assign bus.s0           = ch_q[0];
    assign bus.s1           = ch_q[1];
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_controller.sv
// Directed bench: two controllers (DWELL=2 and DWELL=1) each scanning a behavioural 4:1 mux.
module tb_mux_scan_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] wa;
    logic [3:0] wb;
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    mux_scan_controller_if bus_a ();
    mux_scan_controller_if bus_b ();

    // Real 4:1 mux in front of each controller.
    assign bus_a.y_in = wa[{bus_a.s1, bus_a.s0}];
    assign bus_b.y_in = wb[{bus_b.s1, bus_b.s0}];

    mux_scan_controller #(.DWELL(2), .CNT_W(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    mux_scan_controller #(.DWELL(1), .CNT_W(8)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic seen_done;
        rst_n = 1'b0;
        bus_a.start = 1'b0; bus_a.continuous = 1'b0;
        bus_b.start = 1'b0; bus_b.continuous = 1'b0;
        wa = 4'b0000; wb = 4'b0000;
        #3;
        n_checks++;
        if ({bus_a.s1, bus_a.s0, bus_a.busy, bus_a.done, bus_a.sample_valid} !== 5'b0)
            $display("FAIL reset_ctrl_a: got %b want 00000",
                     {bus_a.s1, bus_a.s0, bus_a.busy, bus_a.done, bus_a.sample_valid});
        else n_pass++;
        n_checks++;
        if (bus_a.sample !== 4'b0000) $display("FAIL reset_sample_a: got %b want 0000", bus_a.sample);
        else n_pass++;
        n_checks++;
        if ({bus_b.s1, bus_b.s0, bus_b.busy, bus_b.done, bus_b.sample_valid} !== 5'b0)
            $display("FAIL reset_ctrl_b: got %b want 00000",
                     {bus_b.s1, bus_b.s0, bus_b.busy, bus_b.done, bus_b.sample_valid});
        else n_pass++;
        n_checks++;
        if (bus_b.sample !== 4'b0000) $display("FAIL reset_sample_b: got %b want 0000", bus_b.sample);
        else n_pass++;

        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Abandon a scan at channel 2 by asserting reset between edges.
        wa = 4'b1111;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        repeat (4) tick();
        n_checks++;
        if ({bus_a.s1, bus_a.s0, bus_a.busy} !== 3'b101)
            $display("FAIL reset_midscan_pre: got %b want 101", {bus_a.s1, bus_a.s0, bus_a.busy});
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus_a.s1, bus_a.s0, bus_a.busy, bus_a.done, bus_a.sample_valid} !== 5'b0)
            $display("FAIL reset_midscan_ctrl: got %b want 00000",
                     {bus_a.s1, bus_a.s0, bus_a.busy, bus_a.done, bus_a.sample_valid});
        else n_pass++;
        n_checks++;
        if (bus_a.sample !== 4'b0000) $display("FAIL reset_midscan_sample: got %b want 0000", bus_a.sample);
        else n_pass++;
        tick(); tick();
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (12) begin
            tick();
            if (bus_a.done === 1'b1) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done !== 1'b0) $display("FAIL reset_no_done: got %b want 0", seen_done);
        else n_pass++;
        n_checks++;
        if ({bus_a.busy, bus_a.sample_valid, bus_a.sample} !== 6'b0)
            $display("FAIL reset_after_idle: got %b want 000000",
                     {bus_a.busy, bus_a.sample_valid, bus_a.sample});
        else n_pass++;
    endtask

    task automatic test_basic_scan();
        wa = 4'b1010;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) tick();
            n_checks++;
            if ({bus_a.s1, bus_a.s0, bus_a.busy, bus_a.done} !== {2'(i / 2), 2'b10})
                $display("FAIL basic_sel[%0d]: got %b want %b", i,
                         {bus_a.s1, bus_a.s0, bus_a.busy, bus_a.done}, {2'(i / 2), 2'b10});
            else n_pass++;
        end
        tick();
        n_checks++;
        if ({bus_a.done, bus_a.busy, bus_a.sample_valid, bus_a.s1, bus_a.s0} !== 5'b11100)
            $display("FAIL basic_done: got %b want 11100",
                     {bus_a.done, bus_a.busy, bus_a.sample_valid, bus_a.s1, bus_a.s0});
        else n_pass++;
        n_checks++;
        if (bus_a.sample !== 4'b1010) $display("FAIL basic_sample: got %b want 1010", bus_a.sample);
        else n_pass++;
        tick();
        n_checks++;
        if ({bus_a.done, bus_a.busy} !== 2'b00)
            $display("FAIL basic_idle: got %b want 00", {bus_a.done, bus_a.busy});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int gap;
        logic got;
        wb = 4'b0110;
        bus_b.continuous = 1'b1;
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) tick();
            n_checks++;
            if ({bus_b.s1, bus_b.s0} !== 2'(i))
                $display("FAIL b2b_sel[%0d]: got %b want %b", i, {bus_b.s1, bus_b.s0}, 2'(i));
            else n_pass++;
        end
        tick();
        n_checks++;
        if ({bus_b.done, bus_b.sample} !== 5'b1_0110)
            $display("FAIL b2b_first: got %b want 10110", {bus_b.done, bus_b.sample});
        else n_pass++;
        wb = 4'b1001;
        gap = 0;
        got = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            tick();
            if (bus_b.done === 1'b1) begin
                got = 1'b1;
                gap = k;
            end
        end
        bus_b.continuous = 1'b0;
        n_checks++;
        if (gap != 5) $display("FAIL b2b_gap: got %0d want 5", gap);
        else n_pass++;
        n_checks++;
        if (bus_b.sample !== 4'b1001) $display("FAIL b2b_second: got %b want 1001", bus_b.sample);
        else n_pass++;
        tick();
        n_checks++;
        if ({bus_b.busy, bus_b.done} !== 2'b00)
            $display("FAIL b2b_stop: got %b want 00", {bus_b.busy, bus_b.done});
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        wa = 4'b0101;
        bus_a.continuous = 1'b0;
        bus_a.start = 1'b1;
        tick();
        // Held start: done at k=8, one IDLE cycle at k=9, rescan, done at k=18, IDLE at k=19.
        for (int k = 0; k < 20; k++) begin
            if (k != 0) tick();
            n_checks++;
            if (bus_a.done !== 1'(k == 8 || k == 18))
                $display("FAIL held_done[%0d]: got %b want %b", k, bus_a.done, 1'(k == 8 || k == 18));
            else n_pass++;
            n_checks++;
            if (bus_a.busy !== 1'(!(k == 9 || k == 19)))
                $display("FAIL held_busy[%0d]: got %b want %b", k, bus_a.busy, 1'(!(k == 9 || k == 19)));
            else n_pass++;
        end
        bus_a.start = 1'b0;
        tick();
        n_checks++;
        if ({bus_a.busy, bus_a.sample} !== 5'b0_0101)
            $display("FAIL held_end: got %b want 00101", {bus_a.busy, bus_a.sample});
        else n_pass++;
    endtask

    task automatic test_stable_output();
        logic got;
        wa = 4'b1100;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (bus_a.done === 1'b1) got = 1'b1;
            else tick();
        end
        n_checks++;
        if (got !== 1'b1) $display("FAIL stable_timeout: got %b want 1", got);
        else n_pass++;
        n_checks++;
        if (bus_a.sample !== 4'b1100) $display("FAIL stable_first: got %b want 1100", bus_a.sample);
        else n_pass++;
        wa = 4'b0011;
        repeat (10) tick();
        n_checks++;
        if ({bus_a.busy, bus_a.sample_valid, bus_a.sample} !== 6'b01_1100)
            $display("FAIL stable_hold: got %b want 011100",
                     {bus_a.busy, bus_a.sample_valid, bus_a.sample});
        else n_pass++;
    endtask

    task automatic test_continuous_stop();
        wa = 4'b0111;
        bus_a.continuous = 1'b1;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k != 0) tick();
            if (k == 2) begin
                n_checks++;
                if ({bus_a.s1, bus_a.s0} !== 2'b01)
                    $display("FAIL cstop_ch1: got %b want 01", {bus_a.s1, bus_a.s0});
                else n_pass++;
                bus_a.continuous = 1'b0;
            end
            n_checks++;
            if (bus_a.done !== 1'(k == 8))
                $display("FAIL cstop_done[%0d]: got %b want %b", k, bus_a.done, 1'(k == 8));
            else n_pass++;
        end
        n_checks++;
        if ({bus_a.busy, bus_a.s1, bus_a.s0, bus_a.sample} !== 7'b000_0111)
            $display("FAIL cstop_idle: got %b want 0000111",
                     {bus_a.busy, bus_a.s1, bus_a.s0, bus_a.sample});
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if ({bus_a.busy, bus_a.done} !== 2'b00)
            $display("FAIL cstop_stay: got %b want 00", {bus_a.busy, bus_a.done});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_back_to_back();
        test_start_ignored();
        test_stable_output();
        test_continuous_stop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
